// File: rtl/video_timing_pkg.sv
// Shared types and timing presets for the multi-mode video timing generator.
package video_timing_pkg;

  localparam int unsigned DEFAULT_CNT_W = 12;
  localparam int unsigned MAX_MODES     = 3;

  typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t h_active;
    cnt_t h_fp;
    cnt_t h_sync;
    cnt_t h_bp;
    cnt_t v_active;
    cnt_t v_fp;
    cnt_t v_sync;
    cnt_t v_bp;
    logic hs_pol;
    logic vs_pol;
  } timing_t;

  typedef timing_t [MAX_MODES-1:0] mode_table_t;

  function automatic timing_t mk_timing(input int unsigned ha, input int unsigned hf,
                                        input int unsigned hs, input int unsigned hb,
                                        input int unsigned va, input int unsigned vf,
                                        input int unsigned vs, input int unsigned vb,
                                        input logic hp, input logic vp);
    timing_t t;
    t.h_active = cnt_t'(ha);
    t.h_fp     = cnt_t'(hf);
    t.h_sync   = cnt_t'(hs);
    t.h_bp     = cnt_t'(hb);
    t.v_active = cnt_t'(va);
    t.v_fp     = cnt_t'(vf);
    t.v_sync   = cnt_t'(vs);
    t.v_bp     = cnt_t'(vb);
    t.hs_pol   = hp;
    t.vs_pol   = vp;
    return t;
  endfunction

  function automatic cnt_t total_w(input timing_t t);
    return t.h_active + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic cnt_t total_l(input timing_t t);
    return t.v_active + t.v_fp + t.v_sync + t.v_bp;
  endfunction

  // Concatenation order puts mode 2 in the MSBs, so index 0 is the last entry.
  localparam mode_table_t MODE_TABLE = {
    mk_timing(1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1),
    mk_timing(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0),
    mk_timing(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1)
  };

endpackage

// File: rtl/video_timing_decode.sv
// Combinational sync / active-draw / new-frame decode from the pixel counters.
module video_timing_decode
  import video_timing_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic [CNT_W-1:0] hcount_in,
  input  logic [CNT_W-1:0] vcount_in,
  input  timing_t          timing_in,
  input  logic             rst_in,
  output logic             hs_out,
  output logic             vs_out,
  output logic             ad_out,
  output logic             nf_out
);

  logic [CNT_W-1:0] h_act, v_act, hs_beg, hs_end, vs_beg, vs_end;
  logic             in_hs, in_vs;

  always_comb begin
    h_act  = CNT_W'(timing_in.h_active);
    v_act  = CNT_W'(timing_in.v_active);
    hs_beg = CNT_W'(timing_in.h_active + timing_in.h_fp);
    hs_end = hs_beg + CNT_W'(timing_in.h_sync);
    vs_beg = CNT_W'(timing_in.v_active + timing_in.v_fp);
    vs_end = vs_beg + CNT_W'(timing_in.v_sync);
    in_hs  = (hcount_in >= hs_beg) && (hcount_in < hs_end);
    in_vs  = (vcount_in >= vs_beg) && (vcount_in < vs_end);
    hs_out = in_hs ? timing_in.hs_pol : ~timing_in.hs_pol;
    vs_out = in_vs ? timing_in.vs_pol : ~timing_in.vs_pol;
    ad_out = ~rst_in && (hcount_in < h_act) && (vcount_in < v_act);
    nf_out = ~rst_in && (hcount_in == h_act) && (vcount_in == v_act);
  end

endmodule

// File: rtl/video_timing_gen_mm.sv
// Multi-mode video timing generator with frame-aligned runtime mode switching.
// Optional per-line interrupt enabled by defining VIDEO_TIMING_LINE_IRQ_EN.
module video_timing_gen_mm
  import video_timing_pkg::*;
#(
  parameter int unsigned NUM_MODES    = 3,
  parameter int unsigned DEFAULT_MODE = 0,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W,
  parameter int unsigned FPS          = 60,
  parameter mode_table_t TIMINGS      = MODE_TABLE
) (
  input  logic                         pixel_clk_in,
  input  logic                         rst_in,
  input  logic [$clog2(NUM_MODES)-1:0] mode_sel_in,
  input  logic                         mode_req_in,
  output logic                         mode_ack_out,
  output logic [$clog2(NUM_MODES)-1:0] mode_out,
  output logic [CNT_W-1:0]             hcount_out,
  output logic [CNT_W-1:0]             vcount_out,
  output logic                         hs_out,
  output logic                         vs_out,
  output logic                         ad_out,
  output logic                         nf_out,
  output logic [$clog2(FPS)-1:0]       fc_out
`ifdef VIDEO_TIMING_LINE_IRQ_EN
  ,
  input  logic [CNT_W-1:0]             line_match_in,
  output logic                         line_irq_out
`endif
);

  localparam int unsigned ModeW = $clog2(NUM_MODES);
  localparam int unsigned FcW   = $clog2(FPS);
  localparam logic [ModeW:0] NumModes = (ModeW + 1)'(NUM_MODES);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [ModeW-1:0] mode_q, mode_d, pend_idx_q, pend_idx_d;
  logic [FcW-1:0]   fc_q, fc_d;
  logic             pend_q, pend_d, ack_q, ack_d;

  timing_t          cur;
  logic [CNT_W-1:0] tw, tl, h_act, v_act;
  logic             h_last, v_last, boundary, req_ok, fc_step;

  always_comb begin
    cur      = TIMINGS[mode_q];
    tw       = CNT_W'(total_w(cur));
    tl       = CNT_W'(total_l(cur));
    h_act    = CNT_W'(cur.h_active);
    v_act    = CNT_W'(cur.v_active);
    h_last   = (h_q == tw - CNT_W'(1));
    v_last   = (v_q == tl - CNT_W'(1));
    boundary = h_last && v_last && pend_q;
    req_ok   = mode_req_in && ({1'b0, mode_sel_in} < NumModes);
    fc_step  = (h_q == h_act - CNT_W'(1)) && (v_q == v_act);
  end

  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    mode_d     = mode_q;
    fc_d       = fc_q;
    pend_d     = pend_q;
    pend_idx_d = pend_idx_q;
    ack_d      = 1'b0;
    if (req_ok) begin
      pend_d     = 1'b1;
      pend_idx_d = mode_sel_in;
    end
    if (boundary) begin
      h_d    = '0;
      v_d    = '0;
      mode_d = pend_idx_q;
      fc_d   = '0;
      ack_d  = 1'b1;
      // A request landing on the boundary cycle waits for the next frame.
      pend_d = req_ok;
    end else begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
      if (fc_step) begin
        fc_d = (fc_q == FcW'(FPS - 1)) ? '0 : fc_q + FcW'(1);
      end
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      h_q        <= '0;
      v_q        <= '0;
      mode_q     <= ModeW'(DEFAULT_MODE);
      fc_q       <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      mode_q     <= mode_d;
      fc_q       <= fc_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      ack_q      <= ack_d;
    end
  end

  video_timing_decode #(
    .CNT_W (CNT_W)
  ) u_decode (
    .hcount_in (h_q),
    .vcount_in (v_q),
    .timing_in (cur),
    .rst_in    (rst_in),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .ad_out    (ad_out),
    .nf_out    (nf_out)
  );

`ifdef VIDEO_TIMING_LINE_IRQ_EN
  logic line_irq_q, line_irq_d;

  always_comb begin
    line_irq_d = (h_q == '0) && (v_q == line_match_in) && (line_match_in < tl);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      line_irq_q <= 1'b0;
    end else begin
      line_irq_q <= line_irq_d;
    end
  end

  assign line_irq_out = line_irq_q;
`endif

  assign mode_ack_out = ack_q;
  assign mode_out     = mode_q;
  assign hcount_out   = h_q;
  assign vcount_out   = v_q;
  assign fc_out       = fc_q;

endmodule

// File: tb/tb_video_timing_gen_mm.sv
// Scoreboard bench for video_timing_gen_mm using scaled-down timing presets.
module tb_video_timing_gen_mm;
  import video_timing_pkg::*;

  // Mode 0: TW 16, TL 8 (+/+); mode 1: TW 10, TL 6 (-/-); mode 2: TW 8, TL 5 (+/+).
  localparam mode_table_t TB_TABLE = {
    mk_timing(4, 1, 1, 2, 2, 1, 1, 1, 1'b1, 1'b1),
    mk_timing(6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0),
    mk_timing(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1)
  };

  logic        clk, rst, mode_req, mode_ack, hs, vs, ad, nf;
  logic [1:0]  mode_sel, mode;
  logic [11:0] hcount, vcount;
  logic [5:0]  fc;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
  logic [11:0] line_match;
  logic        line_irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int ack_exp[$];
  int nf_exp[$];
  bit nf_chk = 1'b0;

  video_timing_gen_mm #(
    .NUM_MODES    (3),
    .DEFAULT_MODE (0),
    .CNT_W        (12),
    .FPS          (60),
    .TIMINGS      (TB_TABLE)
  ) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .mode_sel_in  (mode_sel),
    .mode_req_in  (mode_req),
    .mode_ack_out (mode_ack),
    .mode_out     (mode),
    .hcount_out   (hcount),
    .vcount_out   (vcount),
    .hs_out       (hs),
    .vs_out       (vs),
    .ad_out       (ad),
    .nf_out       (nf),
    .fc_out       (fc)
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    ,
    .line_match_in (line_match),
    .line_irq_out  (line_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wait_at(input int h, input int v);
    int n = 0;
    while (!(hcount == 12'(h) && vcount == 12'(v)) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_at_timeout", {hcount, vcount}, {12'(h), 12'(v)});
  endtask

  // Monitor: every ack pops the next expected mode; nf pops the expected frame count.
  always @(negedge clk) begin
    int e;
    if (mode_ack) begin
      chk("ack_expected", 64'(ack_exp.size() != 0), 64'd1);
      if (ack_exp.size() != 0) begin
        e = ack_exp.pop_front();
        chk("ack_state", {mode, hcount, vcount, fc}, {2'(e), 12'd0, 12'd0, 6'd0});
      end
    end
    if (nf_chk && nf) begin
      chk("nf_expected", 64'(nf_exp.size() != 0), 64'd1);
      if (nf_exp.size() != 0) begin
        e = nf_exp.pop_front();
        chk("nf_fc", {hcount, vcount, fc}, {12'd8, 12'd4, 6'(e)});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          h, v, cnt;
    logic [11:0] eh, ev;
    logic [5:0]  efc;
    logic        ehs, evs, ead, enf;

    rst = 1'b1; mode_req = 1'b0; mode_sel = 2'd0;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    line_match = 12'd3;
`endif
    repeat (3) @(negedge clk);
    chk("rst_state", {hcount, vcount, mode, fc, mode_ack}, 33'd0);
    chk("rst_sync", {hs, vs}, 2'b00);
    chk("rst_ad_nf", {ad, nf}, 2'b00);
    rst = 1'b0;

    // Mode 0 frame: hs at h 10..12, vs at v 5..6, nf at (8,4).
    for (int i = 1; i <= 128; i++) begin
      @(negedge clk);
      h = i % 16; v = (i / 16) % 8;
      eh = 12'(h); ev = 12'(v);
      ehs = (h >= 10 && h < 13); evs = (v >= 5 && v < 7);
      ead = (h < 8 && v < 4);    enf = (h == 8 && v == 4);
      efc = (i >= 72) ? 6'd1 : 6'd0;
      chk($sformatf("walk_m0_%0d", i), {hcount, vcount, hs, vs, ad, nf, fc},
          {eh, ev, ehs, evs, ead, enf, efc});
    end

    // Mid-frame request for mode 1 applies only after (15,7).
    wait_at(0, 2);
    mode_req = 1'b1; mode_sel = 2'd1; ack_exp.push_back(1);
    @(negedge clk); mode_req = 1'b0;
    wait_at(15, 7);
    chk("no_early_switch", {mode, hcount, vcount}, {2'd0, 12'd15, 12'd7});
    // Mode 1: hs low at h 7..8, vs low at v 4, nf at (6,3).
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      h = i % 10; v = i / 10;
      eh = 12'(h); ev = 12'(v);
      ehs = !(h >= 7 && h < 9); evs = (v != 4);
      ead = (h < 6 && v < 3);   enf = (h == 6 && v == 3);
      efc = (i >= 36) ? 6'd1 : 6'd0;
      chk($sformatf("walk_m1_%0d", i), {mode, mode_ack, hcount, vcount, hs, vs, ad, nf, fc},
          {2'd1, (i == 0), eh, ev, ehs, evs, ead, enf, efc});
    end

    // Requests 2, 3 (invalid), 1 in one frame: one ack, last valid wins.
    wait_at(2, 1);
    mode_req = 1'b1; mode_sel = 2'd2;
    @(negedge clk); mode_sel = 2'd3;
    @(negedge clk); mode_sel = 2'd1;
    @(negedge clk); mode_req = 1'b0; ack_exp.push_back(1);
    wait_at(9, 5);
    @(negedge clk);
    chk("last_wins", mode, 2'd1);

    // An invalid request after a valid one leaves the pending one intact.
    wait_at(1, 1);
    mode_req = 1'b1; mode_sel = 2'd2;
    @(negedge clk); mode_sel = 2'd3;
    @(negedge clk); mode_req = 1'b0; ack_exp.push_back(2);
    wait_at(9, 5);
    @(negedge clk);
    chk("invalid_keeps_pending", mode, 2'd2);

    // Invalid request alone: no ack at the boundary.
    wait_at(1, 1);
    mode_req = 1'b1; mode_sel = 2'd3;
    @(negedge clk); mode_req = 1'b0;
    wait_at(7, 4);
    @(negedge clk);
    chk("invalid_no_ack", {mode, mode_ack, hcount, vcount}, {2'd2, 1'b0, 12'd0, 12'd0});

    // Request issued on the boundary cycle is held for the next boundary.
    wait_at(1, 1);
    mode_req = 1'b1; mode_sel = 2'd1; ack_exp.push_back(1);
    @(negedge clk); mode_req = 1'b0;
    wait_at(7, 4);
    mode_req = 1'b1; mode_sel = 2'd0; ack_exp.push_back(0);
    @(negedge clk); mode_req = 1'b0;
    chk("boundary_first", mode, 2'd1);
    wait_at(9, 5);
    @(negedge clk);
    chk("boundary_held", mode, 2'd0);

    // Same-mode request is acked and clears the frame count.
    wait_at(9, 4);
    chk("fc_before_same", fc, 6'd1);
    mode_req = 1'b1; mode_sel = 2'd0; ack_exp.push_back(0);
    @(negedge clk); mode_req = 1'b0;
    wait_at(15, 7);
    @(negedge clk);

    // 61 frames: fc at each nf reads 1..59, 0, 1.
    for (int k = 1; k <= 61; k++) nf_exp.push_back(k % 60);
    nf_chk = 1'b1;
    repeat (61 * 128) @(negedge clk);
    nf_chk = 1'b0;
    chk("nf_count", nf_exp.size(), 0);

    // Reset mid-frame with a request pending: no ack, back to default mode.
    wait_at(0, 1);
    mode_req = 1'b1; mode_sel = 2'd2; ack_exp.push_back(2);
    @(negedge clk); mode_req = 1'b0;
    wait_at(15, 7);
    @(negedge clk);
    wait_at(1, 1);
    mode_req = 1'b1; mode_sel = 2'd1;
    @(negedge clk); mode_req = 1'b0;
    wait_at(5, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_state", {hcount, vcount, mode, mode_ack, ad}, {12'd0, 12'd0, 2'd0, 1'b0, 1'b0});
    @(negedge clk);
    chk("midrst_ad_held", {ad, nf}, 2'b00);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst_mode", mode, 2'd0);

`ifdef VIDEO_TIMING_LINE_IRQ_EN
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (line_irq) begin
        cnt++;
        chk("irq_pos", {hcount, vcount}, {12'd1, 12'd3});
      end
    end
    chk("irq_count", cnt, 2);
    line_match = 12'd8;
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (line_irq) cnt++;
    end
    chk("irq_out_of_range", cnt, 0);
`else
    cnt = 0;
`endif

    chk("ack_queue_drained", ack_exp.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_timing_gen_mm.md
Name: video_timing_gen_mm

Overview:
- Multi-mode successor to the fixed-timing video signal generator in the HDMI path.
- Produces the pixel counters, sync, active-draw, new-frame and frame-count signals for one of NUM_MODES timing presets taken from a package table.
- A request/acknowledge port changes the mode at runtime. The change is applied only at a frame boundary, so the sink never sees a torn frame.
- Sync polarity is set per mode.

Parameters:
- NUM_MODES, 3, number of entries used from video_timing_pkg::MODE_TABLE.
- DEFAULT_MODE, 0, mode in effect after reset.
- CNT_W, 12, width of the h/v counters; must hold the largest total width/lines in the table.
- FPS, 60, frame-counter modulus.

Ports:
- pixel_clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- mode_sel_in  input  $clog2(NUM_MODES)  requested mode index
- mode_req_in  input  1  single-cycle request strobe; mode_sel_in is sampled on this cycle
- mode_ack_out  output  1  one-cycle pulse when the requested mode takes effect
- mode_out  output  $clog2(NUM_MODES)  mode currently in effect
- hcount_out  output  CNT_W  horizontal pixel position
- vcount_out  output  CNT_W  line position
- hs_out  output  1  horizontal sync, at the mode's polarity
- vs_out  output  1  vertical sync, at the mode's polarity
- ad_out  output  1  active drawing
- nf_out  output  1  new-frame pulse
- fc_out  output  $clog2(FPS)  frame counter

Behaviour:
- Definitions, per the current mode: TW = h_active+h_fp+h_sync+h_bp; TL = v_active+v_fp+v_sync+v_bp.
- Reset values:
  - hcount_out=0, vcount_out=0, fc_out=0.
  - mode_out=DEFAULT_MODE.
  - Pending request cleared; mode_ack_out=0.
  - ad_out=0 and nf_out=0; ad_out is forced 0 in every cycle rst_in is high.
  - hs_out/vs_out at the inactive level of DEFAULT_MODE.
- Counters:
  - hcount increments each cycle and wraps at TW-1 to 0.
  - On the h wrap, vcount increments and wraps at TL-1 to 0.
- Decodes are combinational from the current counters and current mode; zero latency relative to hcount_out/vcount_out.
  - hs region: h_active+h_fp <= h < h_active+h_fp+h_sync.
  - vs region: v_active+v_fp <= v < v_active+v_fp+v_sync.
  - Sync output = pol when in its region, else ~pol (pol: 1 = active-high).
  - ad_out = (h < h_active) && (v < v_active).
  - nf_out = (h == h_active) && (v == v_active).
- fc_out increments when the counters step off (h_active-1, v_active), so its new value appears together with nf_out. It wraps FPS-1 -> 0.
- Mode-change handshake:
  - A request with mode_sel_in < NUM_MODES latches a pending index and sets a pending flag.
  - A request with an index >= NUM_MODES is ignored and does not clear an existing pending request.
  - A new valid request while one is pending overwrites the pending index (last wins).
  - Frame boundary = the cycle where h==TW-1 and v==TL-1 while pending is set. On the next cycle:
    - counters = (0,0) under the new mode;
    - mode_out = new index;
    - fc_out = 0;
    - mode_ack_out = 1 for exactly that cycle;
    - pending cleared.
  - A request arriving in the boundary cycle itself is held for the following frame boundary.
  - A request for the current mode is still acknowledged at the boundary, and fc_out is reset.
- Reset mid-frame or mid-request discards the pending request; no ack is issued.

Optional Feature:
- Macro: VIDEO_TIMING_LINE_IRQ_EN.
- When defined, the block adds:
  - input line_match_in [CNT_W];
  - output line_irq_out, a registered one-cycle pulse on the cycle after the counters are at h==0, v==line_match_in. If line_match_in >= TL, no pulse is generated.
  - Reset value of line_irq_out = 0.
- When undefined, neither port exists and there is no related logic.

Decomposition:
- video_timing_pkg holds:
  - timing_t packed struct: h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp (CNT_W each), hs_pol, vs_pol;
  - MODE_TABLE constant:
    - 0 = 1280x720: 110/40/220, 5/5/20, +/+
    - 1 = 640x480: 16/96/48, 10/2/33, -/-
    - 2 = 1920x1080: 88/44/148, 4/5/36, +/+
  - CNT_W default.
- One sub-module, video_timing_decode: combinational hs/vs/ad/nf decode from counters, timing_t and rst_in.

Test Plan:
- Reset, mode 0 -> hcount=vcount=0, mode_out=0, hs/vs=0, ad=0. Frame length 1650*750=1237500 cycles. hs=1 for h 1390..1429; vs=1 for v 725..729. nf high only at (1280,720).
- Request mode 1 at v=100 -> no timing change until (1649,749). The next cycle is (0,0) with mode_out=1, ack=1, fc=0. Then TW=800, TL=525; hs=0 for h 656..751, otherwise 1; vs=0 for v 490..491.
- Requests for mode 2 then mode 1 in the same frame -> one ack; mode_out=1. A request with index 3 -> ignored, no ack.
- Run 61 frames in mode 0 -> fc_out counts 0..59, returns to 0, then reads 1.
- Assert rst_in at h=500, v=300 with a request pending -> next cycle (0,0), mode_out=DEFAULT_MODE, no ack, ad=0 while reset is held.
- VIDEO_TIMING_LINE_IRQ_EN, line_match_in=10 -> one line_irq_out pulse per frame, one cycle after (0,10). line_match_in=800 in mode 0 -> no pulses.
